// File: rtl/arm_pkg.sv
// Shared types and defaults for the ARM pipeline control blocks.
// No logic; state encoding and parameter defaults only.
// Not applicable: no data path, no backpressure.
package arm_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    localparam int MEM_TIMEOUT_DEF = 255;
    localparam int TO_W_DEF        = 8;
    localparam int CNT_W_DEF       = 16;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// Latency: count reflects inc one cycle later.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: pipeline freeze/flush controls plus SRAM start/ready handshake with timeout.
// Latency: controls are combinational (zero cycles); state and counters update on the rising edge.
// Backpressure: an SRAM access freezes the whole pipeline until sram_ready, or forever on timeout.
module pipeline_ctrl
    import arm_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int TO_W        = TO_W_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             sram_ready,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             flush_if_id,
    output logic             bubble_id_exe,
    output logic             freeze_all,
    output logic             sram_start,
    output logic             mem_error,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    state_t          state_q, state_d;
    logic [TO_W-1:0] wait_q, wait_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        freeze_pc     = 1'b0;
        freeze_if_id  = 1'b0;
        flush_if_id   = 1'b0;
        bubble_id_exe = 1'b0;
        freeze_all    = 1'b0;
        sram_start    = 1'b0;
        mem_error     = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (mem_req) begin
                    // Branch/hazard wait: EXE is frozen so they are re-presented later.
                    sram_start   = 1'b1;
                    freeze_pc    = 1'b1;
                    freeze_if_id = 1'b1;
                    freeze_all   = 1'b1;
                    wait_d       = '0;
                    state_d      = ST_MEM_WAIT;
                end else if (branch_taken) begin
                    flush_if_id   = 1'b1;
                    bubble_id_exe = 1'b1;
                end else if (hazard_detected) begin
                    freeze_pc     = 1'b1;
                    freeze_if_id  = 1'b1;
                    bubble_id_exe = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (sram_ready) begin
                    state_d = ST_RUN;
                    if (branch_taken) begin
                        flush_if_id   = 1'b1;
                        bubble_id_exe = 1'b1;
                    end else if (hazard_detected) begin
                        freeze_pc     = 1'b1;
                        freeze_if_id  = 1'b1;
                        bubble_id_exe = 1'b1;
                    end
                end else begin
                    freeze_pc    = 1'b1;
                    freeze_if_id = 1'b1;
                    freeze_all   = 1'b1;
                    wait_d       = wait_q + TO_W'(1);
                    if (wait_q == TO_W'(MEM_TIMEOUT - 1)) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_ERROR: begin
                freeze_pc    = 1'b1;
                freeze_if_id = 1'b1;
                freeze_all   = 1'b1;
                mem_error    = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase

        if (rst) begin
            freeze_pc     = 1'b0;
            freeze_if_id  = 1'b0;
            flush_if_id   = 1'b0;
            bubble_id_exe = 1'b0;
            freeze_all    = 1'b0;
            sram_start    = 1'b0;
            mem_error     = 1'b0;
        end
    end

    assign state = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze_pc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_if_id),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl with MEM_TIMEOUT = 4.
// Expected controls are queued at drive time and compared at the following negedge.
module tb_pipeline_ctrl;
    import arm_pkg::*;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst, hazard_detected, branch_taken, mem_req, sram_ready;
    logic             freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe;
    logic             freeze_all, sram_start, mem_error;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count, flush_count;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MEM_TIMEOUT(4), .TO_W(8), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .mem_req         (mem_req),
        .sram_ready      (sram_ready),
        .freeze_pc       (freeze_pc),
        .freeze_if_id    (freeze_if_id),
        .flush_if_id     (flush_if_id),
        .bubble_id_exe   (bubble_id_exe),
        .freeze_all      (freeze_all),
        .sram_start      (sram_start),
        .mem_error       (mem_error),
        .state           (state),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    // ctl bit order: freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe, freeze_all, sram_start, mem_error
    localparam logic [6:0] Z    = 7'b0000000;
    localparam logic [6:0] HAZ  = 7'b1101000;
    localparam logic [6:0] BR   = 7'b0011000;
    localparam logic [6:0] MEMS = 7'b1100110;
    localparam logic [6:0] FRZ  = 7'b1100100;
    localparam logic [6:0] ERR  = 7'b1100101;

    typedef struct {
        string      tag;
        logic [6:0] ctl;
        logic [1:0] st;
        bit         st_vld;
    } exp_t;

    exp_t q[$];
    int   n_err = 0;
    int   n_chk = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;
    bit   cnt_known = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One cycle: verify counters from completed cycles, apply inputs, queue the expected controls.
    task automatic drive(input string tag, input logic r, input logic h, input logic b,
                         input logic m, input logic rdy, input logic [6:0] ctl,
                         input logic [1:0] st, input bit sv);
        exp_t e;
        @(posedge clk);
        #1;
        if (cnt_known) begin
            chk({tag, "/stall_cnt"}, 32'(stall_count), 32'(exp_stall));
            chk({tag, "/flush_cnt"}, 32'(flush_count), 32'(exp_flush));
        end
        rst = r; hazard_detected = h; branch_taken = b; mem_req = m; sram_ready = rdy;
        e.tag = tag; e.ctl = ctl; e.st = st; e.st_vld = sv;
        q.push_back(e);
        if (r) begin
            exp_stall = 0;
            exp_flush = 0;
            cnt_known = 1;
        end else begin
            exp_stall += int'(ctl[6]);
            exp_flush += int'(ctl[4]);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.tag, "/ctl"}, 32'({freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe,
                                      freeze_all, sram_start, mem_error}), 32'(e.ctl));
            if (e.st_vld) chk({e.tag, "/state"}, 32'(state), 32'(e.st));
        end
    end

    task automatic do_reset();
        for (int i = 0; i < 3; i++) drive("rst", 1, 1, 1, 1, 1, Z, ST_RUN, 0);
        drive("post_rst", 0, 0, 0, 0, 0, Z, ST_RUN, 1);
    endtask

    initial begin
        rst = 1; hazard_detected = 1; branch_taken = 1; mem_req = 1; sram_ready = 1;
        do_reset();

        // Load-use hazard, then branch and hazard together
        drive("haz",   0, 1, 0, 0, 0, HAZ, ST_RUN, 1);
        drive("idle",  0, 0, 0, 0, 0, Z,   ST_RUN, 1);
        drive("brhaz", 0, 1, 1, 0, 0, BR,  ST_RUN, 1);
        drive("idle",  0, 0, 0, 0, 0, Z,   ST_RUN, 1);
        drive("rdy_run_ignored", 0, 0, 0, 0, 1, Z, ST_RUN, 1);

        // Memory access: ready 4 cycles after start
        do_reset();
        drive("m_start", 0, 0, 0, 1, 0, MEMS, ST_RUN, 1);
        for (int i = 0; i < 3; i++) drive("m_wait", 0, 0, 0, 1, 0, FRZ, ST_MEM_WAIT, 1);
        drive("m_ready", 0, 0, 0, 1, 1, Z, ST_MEM_WAIT, 1);
        // Back-to-back access, minimum 2 cycles
        drive("b2b_start", 0, 0, 0, 1, 0, MEMS, ST_RUN, 1);
        drive("b2b_ready", 0, 0, 0, 1, 1, Z, ST_MEM_WAIT, 1);
        drive("idle", 0, 0, 0, 0, 0, Z, ST_RUN, 1);

        // Deferred branch released on the ready cycle
        drive("dbr_start", 0, 0, 1, 1, 0, MEMS, ST_RUN, 1);
        drive("dbr_wait",  0, 0, 1, 1, 0, FRZ, ST_MEM_WAIT, 1);
        drive("dbr_ready", 0, 0, 1, 1, 1, BR, ST_MEM_WAIT, 1);
        drive("idle",      0, 0, 0, 0, 0, Z, ST_RUN, 1);
        // Deferred hazard released on the ready cycle
        drive("dhz_start", 0, 1, 0, 1, 0, MEMS, ST_RUN, 1);
        drive("dhz_ready", 0, 1, 0, 1, 1, HAZ, ST_MEM_WAIT, 1);
        drive("idle",      0, 0, 0, 0, 0, Z, ST_RUN, 1);

        // Ready on the last allowed wait cycle beats the timeout
        drive("late_start", 0, 0, 0, 1, 0, MEMS, ST_RUN, 1);
        for (int i = 0; i < 3; i++) drive("late_wait", 0, 0, 0, 1, 0, FRZ, ST_MEM_WAIT, 1);
        drive("late_ready", 0, 0, 0, 1, 1, Z, ST_MEM_WAIT, 1);
        drive("idle",       0, 0, 0, 0, 0, Z, ST_RUN, 1);

        // Timeout into ERROR, ready ignored, reset recovers
        drive("to_start", 0, 0, 0, 1, 0, MEMS, ST_RUN, 1);
        for (int i = 0; i < 4; i++) drive("to_wait", 0, 0, 0, 1, 0, FRZ, ST_MEM_WAIT, 1);
        drive("err",      0, 0, 0, 1, 0, ERR, ST_ERROR, 1);
        drive("err_rdy",  0, 0, 0, 1, 1, ERR, ST_ERROR, 1);
        drive("err_hold", 0, 1, 1, 0, 0, ERR, ST_ERROR, 1);
        drive("err_rst",  1, 0, 0, 1, 0, Z, ST_ERROR, 1);
        drive("post_err", 0, 0, 0, 0, 0, Z, ST_RUN, 1);
        drive("idle",     0, 0, 0, 0, 0, Z, ST_RUN, 1);

        @(negedge clk);
        #1;
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage ARM pipeline. It takes the hazard detector's `hazard_detected`, the EXE-stage `branch_taken` and the MEM-stage memory request. From these it drives every pipeline-register freeze/flush control, and it runs the start/ready handshake with the multi-cycle SRAM controller, including a timeout. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: maximum number of MEM_WAIT cycles without `sram_ready` before the block enters ERROR. Must be ≥ 2.
- `TO_W`, 8: width of the wait counter. Must satisfy 2^TO_W > MEM_TIMEOUT.
- `CNT_W`, 16: width of the performance counters.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous active-high reset.
- `hazard_detected`  in  1  RAW hazard flag from the hazard unit.
- `branch_taken`  in  1  branch resolved taken in EXE.
- `mem_req`  in  1  MEM-stage instruction is a load or store (`MEM_R_EN|MEM_W_EN`).
- `sram_ready`  in  1  SRAM controller completed the access this cycle.
- `freeze_pc`  out  1  hold the PC.
- `freeze_if_id`  out  1  hold the IF/ID register.
- `flush_if_id`  out  1  load a NOP into IF/ID.
- `bubble_id_exe`  out  1  clear ID/EXE control bits (insert a bubble).
- `freeze_all`  out  1  hold the ID/EXE, EXE/MEM and MEM/WB registers.
- `sram_start`  out  1  one-cycle pulse that starts an SRAM access.
- `mem_error`  out  1  SRAM timeout; sticky until reset.
- `state`  out  2  encoded FSM state, for debug.
- `stall_count`  out  CNT_W  number of cycles with `freeze_pc` = 1.
- `flush_count`  out  CNT_W  number of cycles with `flush_if_id` = 1.

## Operation
FSM states: RUN = 0, MEM_WAIT = 1, ERROR = 2. The control outputs are combinational from the state and the inputs.

In RUN, the first matching rule applies:
1. `mem_req`:
   - Outputs: `sram_start` = 1, and `freeze_pc` = `freeze_if_id` = `freeze_all` = 1.
   - Next state: MEM_WAIT. The wait counter is cleared.
   - A simultaneous `branch_taken` or hazard is deferred. The EXE stage is frozen, so those inputs persist.
2. `branch_taken`: `flush_if_id` = 1 and `bubble_id_exe` = 1, with no freeze. A branch kills the ID instruction, so any hazard this cycle is ignored.
3. `hazard_detected`: `freeze_pc` = 1, `freeze_if_id` = 1, `bubble_id_exe` = 1.
4. Otherwise all controls are 0.

In MEM_WAIT:
- `sram_ready` = 0:
  - Outputs: `freeze_pc` = `freeze_if_id` = `freeze_all` = 1; `sram_start` = 0.
  - The wait counter increments.
  - If the wait counter equals MEM_TIMEOUT-1, the next state is ERROR.
- `sram_ready` = 1:
  - All freezes are 0, and the pipeline advances, capturing the read data.
  - Rules 2 and 3 of RUN apply this cycle. Rule 1 does not: `sram_start` is never asserted in MEM_WAIT.
  - Next state: RUN.
  - `sram_ready` takes priority over timeout in the same cycle.

In ERROR:
- Outputs: `freeze_pc` = `freeze_if_id` = `freeze_all` = 1 and `mem_error` = 1. All other controls are 0.
- The block stays in ERROR until `rst`.

Counters:
- `stall_count` increments on each cycle with `freeze_pc` = 1; `flush_count` increments on each cycle with `flush_if_id` = 1.
- Both saturate at all-ones and never wrap.
- Both keep counting while in ERROR.

`sram_ready` outside MEM_WAIT is ignored.

## Timing
- Reset:
  - While `rst` = 1, every control output is forced to 0.
  - At the next edge: `state` = RUN, the wait counter and both performance counters are 0, and `mem_error` = 0.
  - A reset in MEM_WAIT or ERROR abandons the access, and no `sram_start` is reissued.
- Control outputs have zero latency from the inputs. `state` and the counters update on the rising edge.
- Minimum memory access: 2 cycles. The start cycle is in RUN and the ready cycle is in MEM_WAIT.
  - Total frozen cycles per access = 1 + (number of MEM_WAIT cycles before ready).
- Timeout: with no `sram_ready`, ERROR is entered after MEM_TIMEOUT MEM_WAIT cycles, counted from the cycle after `sram_start`.
- Back-to-back memory instructions:
  - `mem_req` in the cycle after the ready cycle starts a new access.
  - No idle cycle is required.

## Structure
- The shared package `arm_pkg` holds:
  - the state typedef/localparams `ST_RUN`, `ST_MEM_WAIT`, `ST_ERROR`;
  - the default values for MEM_TIMEOUT and CNT_W.
- One natural sub-module is `sat_counter` (parameter width; ports `clk`, `rst`, `inc`, `count`). It is instantiated twice.
- The wait counter and the FSM stay inline.

## Test plan
- Reset check: hold `rst` 3 cycles with all inputs 1 → all outputs 0. After release with inputs 0: `state` = 0 and both counters = 0.
- Load-use hazard: `hazard_detected` = 1 for 1 cycle in RUN → `freeze_pc` = `freeze_if_id` = `bubble_id_exe` = 1 that cycle, and `stall_count` = 1.
- Branch plus hazard: assert `branch_taken` and `hazard_detected` together → `flush_if_id` = `bubble_id_exe` = 1, `freeze_pc` = 0, `flush_count` = 1, `stall_count` unchanged.
- Memory access: `mem_req` = 1 with `sram_ready` arriving 4 cycles after `sram_start` →
  - `sram_start` is a 1-cycle pulse;
  - `freeze_all` = 1 for exactly 4 cycles and 0 on the ready cycle;
  - `state` goes 0 → 1 → 0;
  - `stall_count` = 4.
- Deferred branch: `mem_req` and `branch_taken` both high, with `branch_taken` held → no flush until the ready cycle, then `flush_if_id` = 1 on the ready cycle.
- Timeout, with MEM_TIMEOUT = 4 and no `sram_ready`:
  - ERROR is entered after 4 MEM_WAIT cycles;
  - `mem_error` = 1 and the freezes stay high;
  - a later `sram_ready` is ignored;
  - `rst` returns `state` to 0.
